// File: rtl/rom_8x4_if.sv
// Read port of the 8x4 constant ROM: request (rd_en/addr) and the
// registered response (out/out_valid/parity).
interface rom_8x4_if;
  logic       rd_en;
  logic [2:0] addr;
  logic [3:0] out;
  logic       out_valid;
  logic       parity;

  modport master (
    output rd_en, addr,
    input  out, out_valid, parity
  );

  modport slave (
    input  rd_en, addr,
    output out, out_valid, parity
  );
endinterface

// File: rtl/rom_8x4.sv
// 8-word x 4-bit fixed lookup table with a registered read stage.
// Every entry has even parity, so a registered parity of 1 flags a fault.
module rom_8x4 (
  input  logic     clk,
  input  logic     rst_n,
  rom_8x4_if.slave bus
);

  function automatic logic [3:0] rom_word(input logic [2:0] a);
    logic [3:0] w;
    case (a)
      3'd0:    w = 4'b0000;
      3'd1:    w = 4'b0011;
      3'd2:    w = 4'b0101;
      3'd3:    w = 4'b0110;
      3'd4:    w = 4'b1001;
      3'd5:    w = 4'b1010;
      3'd6:    w = 4'b1100;
      default: w = 4'b1111;
    endcase
    return w;
  endfunction

  logic [3:0] rd_word;
  logic [3:0] out_q;
  logic       par_q;
  logic       vld_q;

  assign rd_word = rom_word(bus.addr);

  // Data and parity are only loaded on a read, so addr is ignored (even if
  // unknown) while rd_en is low; the valid flag drops every idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 4'b0000;
      par_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.rd_en;
      if (bus.rd_en) begin
        out_q <= rd_word;
        par_q <= ^rd_word;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.parity    = par_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_rom_8x4.sv
// Directed bench for rom_8x4: reset, sweeps, hold, gapped reads and
// asynchronous mid-stream reset, against a hand-written content table.
module tb_rom_8x4;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  rom_8x4_if bus ();

  rom_8x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [3:0] exp_rom [8];
  initial begin
    exp_rom[0] = 4'b0000; exp_rom[1] = 4'b0011;
    exp_rom[2] = 4'b0101; exp_rom[3] = 4'b0110;
    exp_rom[4] = 4'b1001; exp_rom[5] = 4'b1010;
    exp_rom[6] = 4'b1100; exp_rom[7] = 4'b1111;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eo, input logic ev);
    chk({tag, ".out"}, bus.out, eo);
    chk({tag, ".valid"}, {3'b0, bus.out_valid}, {3'b0, ev});
    chk({tag, ".parity"}, {3'b0, bus.parity}, 4'b0);
  endtask

  // Drive a request, let one edge sample it, then look just after the edge.
  task automatic cyc(input logic en, input logic [2:0] a);
    bus.rd_en = en;
    bus.addr  = a;
    @(posedge clk);
    #1;
  endtask

  int rev_addr [4];
  int gap_en   [3];

  initial begin
    rev_addr = '{7, 3, 0, 6};
    gap_en   = '{1, 0, 1};

    rst_n     = 1'b0;
    bus.rd_en = 1'b1;
    bus.addr  = 3'd7;
    #1;
    chk_all("reset_t0", 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3'd7);
      chk_all($sformatf("reset_c%0d", i), 4'b0000, 1'b0);
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First edge after release reads addr 7.
    chk_all("release_rd", 4'b1111, 1'b1);

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'(i));
      chk_all($sformatf("sweep_a%0d", i), exp_rom[i], 1'b1);
    end

    cyc(1'b1, 3'd5);
    chk_all("hold_rd5", 4'b1010, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 3'(i));
      chk_all($sformatf("hold_a%0d", i), 4'b1010, 1'b0);
    end
    cyc(1'b0, 3'bxxx);
    chk_all("hold_ax", 4'b1010, 1'b0);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 3'(rev_addr[i]));
      chk_all($sformatf("rev_a%0d", rev_addr[i]), exp_rom[rev_addr[i]], 1'b1);
    end

    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 3'(i));
      chk_all($sformatf("mid_a%0d", i), exp_rom[i], 1'b1);
    end
    // Reset lands between edges: outputs must clear before the next edge.
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_async", 4'b0000, 1'b0);
    #2 rst_n = 1'b1;
    cyc(1'b0, 3'd5);
    chk_all("mid_idle", 4'b0000, 1'b0);
    cyc(1'b1, 3'd2);
    chk_all("mid_rd2", 4'b0101, 1'b1);

    for (int i = 0; i < 3; i++) begin
      cyc(gap_en[i][0], 3'(i + 1));
      chk_all($sformatf("gap_%0d", i), (i == 2) ? 4'b0110 : 4'b0011, gap_en[i][0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
